// File: rtl/led_chase_pkg.sv
// Shared types and helpers for the chasing-LED position engine.
package led_chase_pkg;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  localparam logic MODE_BOUNCE = 1'b0;
  localparam logic MODE_WRAP   = 1'b1;

  // Speed code 3 has no faster/slower meaning of its own; it behaves as 2.
  function automatic logic [1:0] spd_sat(input logic [1:0] s);
    return (s == 2'd3) ? 2'd2 : s;
  endfunction

endpackage

// File: rtl/led_chase_ctrl_tick_gen.sv
// Programmable step divider: period = BASE_DIV << spd_eff clocks, frozen while en=0.
module tick_gen #(
  parameter int unsigned BASE_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] spd_eff,
  output logic       tick
);

  localparam int unsigned CW = $clog2(BASE_DIV * 4 + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   div_m1;

  // Greater-or-equal so a mid-count speed-up fires at once instead of wrapping past.
  always_comb begin
    div_m1 = (32'(BASE_DIV) << spd_eff) - 32'd1;
    tick   = en && (32'(cnt) >= div_m1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_chase_ctrl.sv
// Chasing-LED position engine: bounce/wrap FSM driving registered LED outputs.
// Optional comet trail enabled by defining LED_CHASE_TRAIL_EN.
module led_chase_ctrl
  import led_chase_pkg::*;
#(
  parameter  int unsigned N_LEDS   = 8,
  parameter  int unsigned BASE_DIV = 4,
  localparam int unsigned PW       = $clog2(N_LEDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [1:0]        spd,
  input  logic              mode,
  output logic [PW-1:0]     pos,
  output logic [N_LEDS-1:0] led,
  output logic              step
);

  localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);

  function automatic logic [N_LEDS-1:0] onehot(input logic [PW-1:0] p);
    return N_LEDS'(1) << p;
  endfunction

  logic              tick;
  dir_t              dir;
  dir_t              dir_nxt;
  logic [PW-1:0]     pos_nxt;
  logic [N_LEDS-1:0] led_nxt;

  tick_gen #(
    .BASE_DIV(BASE_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .spd_eff(spd_sat(spd)),
    .tick   (tick)
  );

  always_comb begin
    dir_nxt = dir;
    pos_nxt = pos;
    if (tick) begin
      if (mode == MODE_WRAP) begin
        dir_nxt = DIR_UP;
        pos_nxt = (pos == LAST) ? '0 : pos + 1'b1;
      end else if (dir == DIR_UP) begin
        if (pos == LAST) begin
          dir_nxt = DIR_DOWN;
          pos_nxt = LAST - 1'b1;
        end else begin
          pos_nxt = pos + 1'b1;
        end
      end else begin
        if (pos == '0) begin
          dir_nxt = DIR_UP;
          pos_nxt = PW'(1);
        end else begin
          pos_nxt = pos - 1'b1;
        end
      end
    end
`ifdef LED_CHASE_TRAIL_EN
    // The position being left becomes the trail bit of the new LED image.
    led_nxt = onehot(pos_nxt) | onehot(pos);
`else
    led_nxt = onehot(pos_nxt);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir  <= DIR_UP;
      pos  <= '0;
      led  <= N_LEDS'(1);
      step <= 1'b0;
    end else begin
      step <= tick;
      if (tick) begin
        dir <= dir_nxt;
        pos <= pos_nxt;
        led <= led_nxt;
      end
    end
  end

endmodule
